// File: rtl/vert_pkg.sv
// Shared types and constants for the vertex rotation stage.
// Holds the FSM encoding, angle range and screen-centre defaults.
package vert_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_FETCH,
        ST_CALC,
        ST_OUT,
        ST_DONE
    } state_e;

    localparam int ANGLE_MAX = 360;
    localparam int ANGLE_W   = 9;
    localparam int CX_DEF    = 320;
    localparam int CY_DEF    = 240;

    // Fraction bits of a signed Q1.x trig value: sign plus one integer bit.
    function automatic int trig_frac(input int trig_w);
        return trig_w - 2;
    endfunction

endpackage

// File: rtl/angle_anim.sv
// Free-running rotation angle: a tick prescaler advances the angle
// by ANGLE_STEP degrees modulo 360 while animation is enabled.
module angle_anim
    import vert_pkg::*;
#(
    parameter int TICKS_PER_STEP = 333333,
    parameter int ANGLE_STEP     = 1
) (
    input  logic               clk_pix,
    input  logic               rst_n,
    input  logic               anim_en,
    output logic [ANGLE_W-1:0] angle
);

    localparam int TW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam int SW = ANGLE_W + 1;

    logic [TW-1:0]      tick_q, tick_d;
    logic [ANGLE_W-1:0] angle_q, angle_d;
    logic [SW-1:0]      sum;

    always_comb begin
        tick_d  = tick_q;
        angle_d = angle_q;
        sum     = {1'b0, angle_q} + SW'(ANGLE_STEP);
        if (anim_en) begin
            if (tick_q == TW'(TICKS_PER_STEP - 1)) begin
                tick_d = '0;
                // Step is below 360, so one subtraction wraps the sum.
                if (sum >= SW'(ANGLE_MAX)) begin
                    angle_d = ANGLE_W'(sum - SW'(ANGLE_MAX));
                end else begin
                    angle_d = sum[ANGLE_W-1:0];
                end
            end else begin
                tick_d = tick_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            tick_q  <= '0;
            angle_q <= '0;
        end else begin
            tick_q  <= tick_d;
            angle_q <= angle_d;
        end
    end

    assign angle = angle_q;

endmodule

// File: rtl/vert_rotor.sv
// Per-frame Y-axis rotation of NUM_VERTS model vertices into screen
// coordinates, streamed to triangle setup over valid/ready.
module vert_rotor
    import vert_pkg::*;
#(
    parameter int MODEL_W        = 8,
    parameter int TRIG_W         = 12,
    parameter int COORD_W        = 10,
    parameter int NUM_VERTS      = 3,
    parameter int TICKS_PER_STEP = 333333,
    parameter int ANGLE_STEP     = 1,
    parameter int CX             = CX_DEF,
    parameter int CY             = CY_DEF,
    localparam int AW = (NUM_VERTS > 1) ? $clog2(NUM_VERTS) : 1
) (
    input  logic                      clk_pix,
    input  logic                      rst_n,
    input  logic                      anim_en,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [ANGLE_W-1:0]        trig_angle,
    input  logic signed [TRIG_W-1:0]  trig_cos,
    input  logic signed [TRIG_W-1:0]  trig_sin,
    output logic [AW-1:0]             vert_addr,
    input  logic signed [MODEL_W-1:0] vert_x,
    input  logic signed [MODEL_W-1:0] vert_y,
    input  logic signed [MODEL_W-1:0] vert_z,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [AW-1:0]             out_idx,
    output logic [COORD_W-1:0]        out_x,
    output logic [COORD_W-1:0]        out_y
);

    localparam int FRAC  = trig_frac(TRIG_W);
    localparam int SUM_W = MODEL_W + TRIG_W + 1;

    logic [ANGLE_W-1:0] live_angle;

    state_e                    state_q, state_d;
    logic [ANGLE_W-1:0]        aq_q, aq_d;
    logic signed [TRIG_W-1:0]  cos_q, cos_d;
    logic signed [TRIG_W-1:0]  sin_q, sin_d;
    logic [AW-1:0]             i_q, i_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      ov_q, ov_d;
    logic [AW-1:0]             idx_q, idx_d;
    logic [COORD_W-1:0]        ox_q, ox_d;
    logic [COORD_W-1:0]        oy_q, oy_d;
    logic signed [SUM_W-1:0]   prod_x, prod_z, sum, xr;

    angle_anim #(
        .TICKS_PER_STEP(TICKS_PER_STEP),
        .ANGLE_STEP    (ANGLE_STEP)
    ) u_anim (
        .clk_pix(clk_pix),
        .rst_n  (rst_n),
        .anim_en(anim_en),
        .angle  (live_angle)
    );

    always_comb begin
        prod_x  = SUM_W'(vert_x) * SUM_W'(cos_q);
        prod_z  = SUM_W'(vert_z) * SUM_W'(sin_q);
        sum     = prod_x + prod_z;
        xr      = sum >>> FRAC;
        state_d = state_q;
        aq_d    = aq_q;
        cos_d   = cos_q;
        sin_d   = sin_q;
        i_d     = i_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ov_d    = ov_q;
        idx_d   = idx_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    aq_d    = live_angle;
                    busy_d  = 1'b1;
                    state_d = ST_TRIG;
                end
            end
            ST_TRIG: begin
                // LUT was addressed with the live angle in the start cycle.
                cos_d   = trig_cos;
                sin_d   = trig_sin;
                i_d     = '0;
                state_d = ST_FETCH;
            end
            ST_FETCH: state_d = ST_CALC;
            ST_CALC: begin
                ox_d    = COORD_W'(xr + SUM_W'(CX));
                oy_d    = COORD_W'(SUM_W'(vert_y) + SUM_W'(CY));
                idx_d   = i_q;
                ov_d    = 1'b1;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    ov_d = 1'b0;
                    if (i_q == AW'(NUM_VERTS - 1)) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        i_d     = i_q + AW'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            aq_q    <= '0;
            cos_q   <= '0;
            sin_q   <= '0;
            i_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ov_q    <= 1'b0;
            idx_q   <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
        end else begin
            state_q <= state_d;
            aq_q    <= aq_d;
            cos_q   <= cos_d;
            sin_q   <= sin_d;
            i_q     <= i_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ov_q    <= ov_d;
            idx_q   <= idx_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
        end
    end

    assign trig_angle = (state_q == ST_IDLE) ? live_angle : aq_q;
    assign vert_addr  = i_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign out_valid  = ov_q;
    assign out_idx    = idx_q;
    assign out_x      = ox_q;
    assign out_y      = oy_q;

endmodule

// File: tb/tb_vert_rotor.sv
// Self-checking bench for vert_rotor: frame vector table plus
// angle animation, stall, re-start and mid-frame reset sequences.
module tb_vert_rotor;

    localparam int NV    = 3;
    localparam int TICKS = 4;
    localparam int STEP  = 7;
    localparam int CXT   = 320;
    localparam int CYT   = 240;
    localparam int NF    = 8;

    typedef struct {
        int c;
        int s;
        int vx[NV];
        int vy[NV];
        int vz[NV];
        int ex[NV];
        int ey[NV];
    } frame_t;

    logic              clk_pix = 1'b0;
    logic              rst_n;
    logic              anim_en;
    logic              start;
    logic              busy;
    logic              done;
    logic [8:0]        trig_angle;
    logic signed [11:0] trig_cos;
    logic signed [11:0] trig_sin;
    logic [1:0]        vert_addr;
    logic signed [7:0] vert_x;
    logic signed [7:0] vert_y;
    logic signed [7:0] vert_z;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_idx;
    logic [9:0]        out_x;
    logic [9:0]        out_y;

    frame_t tbl[NF];
    int     cos_set, sin_set;
    logic signed [7:0] rom_x[NV];
    logic signed [7:0] rom_y[NV];
    logic signed [7:0] rom_z[NV];
    int     en_cnt;
    int     n_chk = 0;
    int     n_fail = 0;

    vert_rotor #(
        .NUM_VERTS     (NV),
        .TICKS_PER_STEP(TICKS),
        .ANGLE_STEP    (STEP)
    ) dut (
        .clk_pix   (clk_pix),
        .rst_n     (rst_n),
        .anim_en   (anim_en),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .trig_angle(trig_angle),
        .trig_cos  (trig_cos),
        .trig_sin  (trig_sin),
        .vert_addr (vert_addr),
        .vert_x    (vert_x),
        .vert_y    (vert_y),
        .vert_z    (vert_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_x     (out_x),
        .out_y     (out_y)
    );

    always #5 clk_pix = ~clk_pix;

    // One-cycle latency trig LUT and vertex ROM models.
    always @(posedge clk_pix) begin
        trig_cos <= 12'(cos_set);
        trig_sin <= 12'(sin_set);
        vert_x   <= rom_x[vert_addr];
        vert_y   <= rom_y[vert_addr];
        vert_z   <= rom_z[vert_addr];
    end

    always @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) en_cnt <= 0;
        else if (anim_en) en_cnt <= en_cnt + 1;
    end

    function automatic int exp_angle();
        return (STEP * (en_cnt / TICKS)) % 360;
    endfunction

    function automatic int floor_div(input int p, input int d);
        if (p >= 0) return p / d;
        return -((-p + d - 1) / d);
    endfunction

    function automatic int ref_x(input int x, input int z, input int c, input int s);
        int xr;
        xr = floor_div(x * c + z * s, 1024);
        return ((CXT + xr) % 1024 + 1024) % 1024;
    endfunction

    function automatic int ref_y(input int y);
        return ((CYT + y) % 1024 + 1024) % 1024;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_v(input int k, input int i, input int x, input int y,
                         input int z, input int ex, input int ey);
        tbl[k].vx[i] = x;
        tbl[k].vy[i] = y;
        tbl[k].vz[i] = z;
        tbl[k].ex[i] = ex;
        tbl[k].ey[i] = ey;
    endtask

    task automatic load(input int k);
        cos_set = tbl[k].c;
        sin_set = tbl[k].s;
        for (int i = 0; i < NV; i++) begin
            rom_x[i] = 8'(tbl[k].vx[i]);
            rom_y[i] = 8'(tbl[k].vy[i]);
            rom_z[i] = 8'(tbl[k].vz[i]);
        end
    endtask

    task automatic run_frame(input int k, input int stall_v, input int stall_n,
                             input bit repulse);
        int vi, st, cyc, exp_aq;
        bit seen_done;
        load(k);
        @(negedge clk_pix);
        exp_aq    = exp_angle();
        start     = 1'b1;
        out_ready = 1'b1;
        vi = 0;
        st = 0;
        cyc = 0;
        seen_done = 1'b0;
        while (!seen_done && cyc < 60) begin
            @(negedge clk_pix);
            cyc++;
            start = repulse && (cyc == 5);
            chk("trig_angle_latched", int'(trig_angle), exp_aq);
            if (done) begin
                chk("done_cycle", cyc, 3 * NV + 2 + stall_n);
                chk("done_vertex_count", vi, NV);
                seen_done = 1'b1;
            end else if (out_valid) begin
                chk("out_idx", int'(out_idx), vi);
                chk("out_x", int'(out_x), tbl[k].ex[vi]);
                chk("out_y", int'(out_y), tbl[k].ey[vi]);
                if (vi == stall_v && st < stall_n) begin
                    out_ready = 1'b0;
                    st++;
                end else begin
                    out_ready = 1'b1;
                    vi++;
                end
            end else begin
                out_ready = 1'b1;
            end
        end
        start = 1'b0;
        if (!seen_done) chk("done_seen", 0, 1);
        @(negedge clk_pix);
        chk("busy_after_done", int'(busy), 0);
        chk("done_one_cycle", int'(done), 0);
        repeat (3) @(negedge clk_pix);
        chk("no_restart_busy", int'(busy), 0);
    endtask

    initial begin
        int n;
        tbl[0].c = 1024;
        tbl[0].s = 0;
        set_v(0, 0, 10, 5, 0, 330, 245);
        set_v(0, 1, -10, 5, 0, 310, 245);
        set_v(0, 2, 0, -20, 30, 320, 220);
        tbl[1].c = 0;
        tbl[1].s = 1024;
        set_v(1, 0, 0, 0, 40, 360, 240);
        set_v(1, 1, 5, -3, -20, 300, 237);
        set_v(1, 2, -128, 127, 127, 447, 367);
        tbl[2].c = 0;
        tbl[2].s = 1023;
        set_v(2, 0, 0, 0, -1, 319, 240);
        set_v(2, 1, 0, 0, 1, 320, 240);
        set_v(2, 2, 0, 0, -127, 193, 240);
        for (int k = 3; k < NF; k++) begin
            tbl[k].c = int'($urandom_range(0, 2048)) - 1024;
            tbl[k].s = int'($urandom_range(0, 2048)) - 1024;
            for (int i = 0; i < NV; i++) begin
                int x, y, z;
                x = int'($urandom_range(0, 255)) - 128;
                y = int'($urandom_range(0, 255)) - 128;
                z = int'($urandom_range(0, 255)) - 128;
                set_v(k, i, x, y, z, ref_x(x, z, tbl[k].c, tbl[k].s), ref_y(y));
            end
        end

        rst_n = 1'b0;
        anim_en = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        load(0);
        repeat (2) @(negedge clk_pix);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_trig_angle", int'(trig_angle), 0);
        chk("rst_vert_addr", int'(vert_addr), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_out_x", int'(out_x), 0);
        chk("rst_out_y", int'(out_y), 0);
        rst_n = 1'b1;
        @(negedge clk_pix);

        run_frame(0, -1, 0, 1'b0);
        run_frame(0, 1, 5, 1'b0);
        run_frame(1, -1, 0, 1'b0);
        run_frame(2, -1, 0, 1'b0);
        anim_en = 1'b1;
        run_frame(3, -1, 0, 1'b1);
        for (int k = 4; k < NF; k++) begin
            anim_en = 1'($urandom_range(0, 1));
            run_frame(k, (k == 5) ? 2 : -1, (k == 5) ? 3 : 0, 1'b0);
        end
        anim_en = 1'b0;

        load(0);
        @(negedge clk_pix);
        start = 1'b1;
        @(negedge clk_pix);
        start = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk_pix);
            n++;
        end
        chk("pre_reset_out_valid", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_out_x", int'(out_x), 0);
        chk("midrst_trig_angle", int'(trig_angle), 0);
        @(negedge clk_pix);
        rst_n = 1'b1;
        @(negedge clk_pix);
        chk("postrst_done", int'(done), 0);
        run_frame(0, -1, 0, 1'b0);

        anim_en = 1'b1;
        n = 0;
        while (exp_angle() != 357 && n < 2000) begin
            @(negedge clk_pix);
            n++;
        end
        chk("angle_357", int'(trig_angle), 357);
        repeat (4) @(negedge clk_pix);
        chk("angle_wrap_4", int'(trig_angle), 4);
        anim_en = 1'b0;
        repeat (10) @(negedge clk_pix);
        chk("angle_frozen", int'(trig_angle), 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
